// File: rtl/apb_pkg.sv
// Shared APB definitions used by the bridge and every slave on the bus.
package apb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } apb_state_e;

  localparam int APB_DEC_W        = 12;
  localparam int APB_DEF_WAIT_CYC = 1;
  localparam int APB_DEF_DEPTH    = 16;
endpackage

// File: rtl/apb_slave_ram.sv
// Word array for the APB slave: write on the clock edge, read combinationally.
module apb_slave_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small word memory, fixed wait-state insertion and
// pslverr on misaligned or out-of-range addresses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int SLV_IDX  = 0,
  parameter int WAIT_CYC = APB_DEF_WAIT_CYC,
  parameter int DEPTH    = APB_DEF_DEPTH
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);
  localparam int AW = $clog2(DEPTH);
  // The SETUP access cycle is already one wait cycle, so WAIT holds WAIT_CYC-1 more.
  localparam logic [2:0] WAIT_LD = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;
  localparam logic [APB_DEC_W-3:0] DEPTH_LIM = DEPTH[APB_DEC_W-3:0];

  apb_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [APB_DEC_W-1:0] addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic [31:0]          wdata_q, wdata_d;

  logic        sel, done, addr_err, we;
  logic [31:0] rdata;
  logic        unused_ok;

  assign sel       = psel[SLV_IDX];
  assign unused_ok = ^{psel, paddr[31:APB_DEC_W]};
  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[APB_DEC_W-1:2] >= DEPTH_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    pready  = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sel && !penable) begin
          state_d = ST_SETUP;
          addr_d  = paddr[APB_DEC_W-1:0];
          wr_d    = pwrite;
          wdata_d = pwdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!sel || !penable) begin
          state_d = ST_IDLE;
        end else if (WAIT_CYC == 0) begin
          done    = 1'b1;
          state_d = ST_DONE;
        end else begin
          pready  = 1'b0;
          cnt_d   = WAIT_LD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!sel || !penable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          done    = 1'b1;
          state_d = ST_DONE;
        end else begin
          pready  = 1'b0;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we      = done && wr_q && !addr_err;
  assign pslverr = done && addr_err;
  assign prdata  = (done && !wr_q && !addr_err) ? rdata : 32'd0;

  apb_slave_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .hclk   (hclk),
    .hreset (hreset),
    .we     (we),
    .waddr  (addr_q[AW+1:2]),
    .wdata  (wdata_q),
    .raddr  (addr_q[AW+1:2]),
    .rdata  (rdata)
  );
endmodule

// File: tb/tb_apb_slave_mem.sv
// Two slaves on one APB bus: slot 0 with one wait state, slot 1 with zero waits.
module tb_apb_slave_mem;
  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [2][16];

  always #5 hclk = ~hclk;

  apb_slave_mem #(.SLV_IDX(0), .WAIT_CYC(1), .DEPTH(16)) dut_a (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

  apb_slave_mem #(.SLV_IDX(1), .WAIT_CYC(0), .DEPTH(16)) dut_b (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    psel = 3'b000; penable = 1'b0;
    @(posedge hclk) #1;
  endtask

  task automatic do_reset();
    hreset = 1'b1; psel = 3'b000; penable = 1'b0;
    @(posedge hclk) #1;
    @(posedge hclk) #1;
    hreset = 1'b0;
    for (int t = 0; t < 2; t++) for (int i = 0; i < 16; i++) mdl[t][i] = '0;
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input int tgt, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output bit err, output int waits);
    bit got;
    got = 1'b0; waits = 0; rd = '0; err = 1'b0;
    psel = (tgt == 0) ? 3'b001 : 3'b010;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge hclk) #1;
    penable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge hclk);
      if ((tgt == 0) ? pready_a : pready_b) begin
        rd  = (tgt == 0) ? prdata_a : prdata_b;
        err = (tgt == 0) ? pslverr_a : pslverr_b;
        got = 1'b1;
        break;
      end
      waits++;
      @(posedge hclk) #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout: no pready within 20 cycles addr %0h", addr);
    end
    @(posedge hclk) #1;
  endtask

  // Reference: word memory per slot, errors from alignment / range, fixed waits per slot.
  task automatic model(input int tgt, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int waits);
    int idx;
    idx   = int'(addr[11:2]);
    err   = (addr[1:0] != 2'b00) || (idx >= 16);
    waits = (tgt == 0) ? 1 : 0;
    rd    = '0;
    if (!err) begin
      if (wr) mdl[tgt][idx] = wd;
      else    rd = mdl[tgt][idx];
    end
  endtask

  task automatic run_check(input string name, input int tgt, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] erd, ard;
    bit ee, ae;
    int ew, aw;
    model(tgt, wr, addr, wd, erd, ee, ew);
    xfer(tgt, wr, addr, wd, ard, ae, aw);
    chk({name, ".rdata"}, ard, erd);
    chk({name, ".err"}, 32'(ae), 32'(ee));
    chk({name, ".waits"}, aw, ew);
  endtask

  typedef struct {
    int          tgt;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          waits;
  } vec_t;

  initial begin
    vec_t tbl [13];
    logic [31:0] rd, drop;
    bit err, dropb;
    int w1, w2;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    logic [31:0] rd, mrd;
    bit err, merr;
    int w1, w2, mw;

    hreset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    do_reset();
    @(negedge hclk);
    chk("rst.pready", 32'(pready_a), 32'd1);
    chk("rst.pslverr", 32'(pslverr_a), 32'd0);
    chk("rst.prdata", prdata_a, 32'd0);
    @(posedge hclk) #1;

    tbl[0]  = '{0, 1'b1, 32'h004, 32'hA5A5_0001, 32'h0,         1'b0, 1};
    tbl[1]  = '{0, 1'b0, 32'h004, 32'h0,         32'hA5A5_0001, 1'b0, 1};
    tbl[2]  = '{0, 1'b1, 32'h040, 32'h1111_1111, 32'h0,         1'b1, 1};
    tbl[3]  = '{0, 1'b1, 32'h006, 32'h2222_2222, 32'h0,         1'b1, 1};
    tbl[4]  = '{0, 1'b0, 32'h040, 32'h0,         32'h0,         1'b1, 1};
    tbl[5]  = '{0, 1'b0, 32'h006, 32'h0,         32'h0,         1'b1, 1};
    tbl[6]  = '{0, 1'b1, 32'h03C, 32'hCAFE_F00D, 32'h0,         1'b0, 1};
    tbl[7]  = '{0, 1'b0, 32'h03C, 32'h0,         32'hCAFE_F00D, 1'b0, 1};
    tbl[8]  = '{1, 1'b1, 32'h000, 32'h0BAD_BEEF, 32'h0,         1'b0, 0};
    tbl[9]  = '{1, 1'b0, 32'h000, 32'h0,         32'h0BAD_BEEF, 1'b0, 0};
    tbl[10] = '{0, 1'b0, 32'h000, 32'h0,         32'h0,         1'b0, 1};
    tbl[11] = '{1, 1'b1, 32'hFFC, 32'h3333_3333, 32'h0,         1'b1, 0};
    tbl[12] = '{0, 1'b0, 32'h0000_1004, 32'h0,   32'hA5A5_0001, 1'b0, 1};

    for (int i = 0; i < 13; i++) begin
      xfer(tbl[i].tgt, tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err, w1);
      model(tbl[i].tgt, tbl[i].wr, tbl[i].addr, tbl[i].wd, mrd, merr, mw);
      chk($sformatf("vec%0d.rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d.err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d.waits", i), w1, tbl[i].waits);
      idle();
    end

    // errored writes must leave every word intact
    for (int i = 0; i < 16; i++) begin
      run_check($sformatf("readback%0d", i), 0, 1'b0, 32'(i * 4), 32'h0);
      idle();
    end

    // back-to-back writes through DONE->SETUP
    xfer(0, 1'b1, 32'h008, 32'h0000_0808, rd, err, w1);
    xfer(0, 1'b1, 32'h00C, 32'h0000_0C0C, rd, err, w2);
    idle();
    mdl[0][2] = 32'h0000_0808; mdl[0][3] = 32'h0000_0C0C;
    chk("b2b.waits", w1 + w2, 2);
    run_check("b2b.rd8", 0, 1'b0, 32'h008, 32'h0); idle();
    run_check("b2b.rdC", 0, 1'b0, 32'h00C, 32'h0); idle();

    // transfer to the other slot leaves slot 0 untouched
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h004; pwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    chk("othsel.setup.pready", 32'(pready_a), 32'd1);
    @(posedge hclk) #1;
    penable = 1'b1;
    @(negedge hclk);
    chk("othsel.acc.pready", 32'(pready_a), 32'd1);
    chk("othsel.acc.prdata", prdata_a, 32'd0);
    chk("othsel.b.pready", 32'(pready_b), 32'd1);
    @(posedge hclk) #1;
    idle();
    mdl[1][1] = 32'hFFFF_FFFF;
    run_check("othsel.rdA", 0, 1'b0, 32'h004, 32'h0); idle();
    run_check("othsel.rdB", 1, 1'b0, 32'h004, 32'h0); idle();

    // penable without a SETUP phase is ignored
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h004; pwdata = 32'hDEAD_DEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      chk($sformatf("nosetup%0d.pready", c), 32'(pready_a), 32'd1);
      @(posedge hclk) #1;
    end
    idle();
    run_check("nosetup.rd", 0, 1'b0, 32'h004, 32'h0); idle();

    // penable falls during WAIT: abort, no write
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h008; pwdata = 32'h7777_7777;
    @(posedge hclk) #1;
    penable = 1'b1;
    @(negedge hclk);
    chk("abortA.setup.pready", 32'(pready_a), 32'd0);
    @(posedge hclk) #1;
    penable = 1'b0;
    @(negedge hclk);
    chk("abortA.pslverr", 32'(pslverr_a), 32'd0);
    @(posedge hclk) #1;
    idle();
    run_check("abortA.rd", 0, 1'b0, 32'h008, 32'h0); idle();

    // zero-wait slot: psel drops in SETUP
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h020; pwdata = 32'h5555_5555;
    @(posedge hclk) #1;
    psel = 3'b000; penable = 1'b1;
    @(negedge hclk);
    chk("abortB.pslverr", 32'(pslverr_b), 32'd0);
    @(posedge hclk) #1;
    idle();
    run_check("abortB.rd", 1, 1'b0, 32'h020, 32'h0); idle();

    // reset during the WAIT cycle of a write
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h1234_5678;
    @(posedge hclk) #1;
    penable = 1'b1;
    @(posedge hclk) #1;
    hreset = 1'b1;
    @(posedge hclk) #1;
    hreset = 1'b0; psel = 3'b000; penable = 1'b0;
    for (int t = 0; t < 2; t++) for (int i = 0; i < 16; i++) mdl[t][i] = '0;
    @(negedge hclk);
    chk("rstwait.pready", 32'(pready_a), 32'd1);
    @(posedge hclk) #1;
    run_check("rstwait.rd10", 0, 1'b0, 32'h010, 32'h0); idle();
    run_check("rstwait.rd4", 0, 1'b0, 32'h004, 32'h0); idle();
    run_check("rstwait.rdB", 1, 1'b0, 32'h000, 32'h0); idle();

    // random traffic against the model
    for (int n = 0; n < 80; n++) begin
      int tgt;
      bit wr;
      logic [31:0] addr;
      tgt  = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) addr = addr | 32'h0000_3000;
      run_check($sformatf("rnd%0d", n), tgt, wr, addr, $urandom);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
